// File: rtl/uart_cmd_wrapper.sv
// uart_cmd_wrapper: UART link end that assembles two-byte commands and sends one-byte responses
module uart_cmd_wrapper #(
   parameter int BAUD_DIV = 2604,
   parameter int TO_BITS  = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RX,
   output logic        TX,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic        trmt,
   input  logic [7:0]  resp,
   output logic        tx_done
);
   localparam int BW = $clog2(BAUD_DIV);
   localparam int TW = $clog2(TO_BITS * BAUD_DIV + 1);
   localparam logic [BW-1:0] HALF    = BW'(BAUD_DIV / 2);
   localparam logic [BW-1:0] LAST    = BW'(BAUD_DIV - 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TO_BITS * BAUD_DIV - 1);

   typedef enum logic {RX_IDLE, RX_RECV} rx_st_t;
   typedef enum logic {WAIT_HIGH, WAIT_LOW} by_st_t;
   typedef enum logic {TX_IDLE, TX_SEND} tx_st_t;

   rx_st_t rx_st_q, rx_st_d;
   by_st_t by_st_q, by_st_d;
   tx_st_t tx_st_q, tx_st_d;
   logic rx_s1_q, rx_s2_q, rx_prev_q;
   logic [BW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
   logic [3:0] rx_bit_q, rx_bit_d, tx_bit_q, tx_bit_d;
   logic [7:0] rx_sh_q, rx_sh_d, hi_q, hi_d;
   logic [9:0] tx_sh_q, tx_sh_d;
   logic [TW-1:0] to_q, to_d;
   logic [15:0] cmd_q, cmd_d;
   logic stb_q, stb_d, rdy_q, rdy_d, done_q, done_d;
   logic start, set_rdy, wipe_rdy;

   assign start   = (rx_st_q == RX_IDLE) && rx_prev_q && !rx_s2_q;
   assign TX      = (tx_st_q == TX_SEND) ? tx_sh_q[0] : 1'b1;
   assign cmd     = cmd_q;
   assign cmd_rdy = rdy_q;
   assign tx_done = done_q;

   // All state registers, synchronous reset to idle
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
         rx_st_q   <= RX_IDLE;
         rx_cnt_q  <= '0;
         rx_bit_q  <= '0;
         rx_sh_q   <= '0;
         stb_q     <= 1'b0;
         by_st_q   <= WAIT_HIGH;
         hi_q      <= '0;
         to_q      <= '0;
         cmd_q     <= '0;
         rdy_q     <= 1'b0;
         tx_st_q   <= TX_IDLE;
         tx_cnt_q  <= '0;
         tx_bit_q  <= '0;
         tx_sh_q   <= '0;
         done_q    <= 1'b0;
      end else begin
         rx_s1_q   <= RX;
         rx_s2_q   <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
         rx_st_q   <= rx_st_d;
         rx_cnt_q  <= rx_cnt_d;
         rx_bit_q  <= rx_bit_d;
         rx_sh_q   <= rx_sh_d;
         stb_q     <= stb_d;
         by_st_q   <= by_st_d;
         hi_q      <= hi_d;
         to_q      <= to_d;
         cmd_q     <= cmd_d;
         rdy_q     <= rdy_d;
         tx_st_q   <= tx_st_d;
         tx_cnt_q  <= tx_cnt_d;
         tx_bit_q  <= tx_bit_d;
         tx_sh_q   <= tx_sh_d;
         done_q    <= done_d;
      end
   end

   // Receiver: half-bit first delay, then one sample per bit period at mid-bit
   always_comb begin
      rx_st_d  = rx_st_q;
      rx_cnt_d = rx_cnt_q;
      rx_bit_d = rx_bit_q;
      rx_sh_d  = rx_sh_q;
      stb_d    = 1'b0;
      if (rx_st_q == RX_IDLE) begin
         if (start) begin
            rx_st_d  = RX_RECV;
            rx_cnt_d = HALF;
            rx_bit_d = '0;
         end
      end else if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - 1'b1;
      else begin
         rx_cnt_d = LAST;
         rx_bit_d = rx_bit_q + 1'b1;
         if (rx_bit_q == 4'd0) begin
            if (rx_s2_q) rx_st_d = RX_IDLE;
         end else if (rx_bit_q == 4'd9) begin
            rx_st_d = RX_IDLE;
            stb_d   = rx_s2_q;
         end else rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
      end
   end

   // Byte pairing; the inter-byte timeout only runs while the receiver is idle
   always_comb begin
      by_st_d  = by_st_q;
      hi_d     = hi_q;
      to_d     = '0;
      cmd_d    = cmd_q;
      set_rdy  = 1'b0;
      wipe_rdy = 1'b0;
      if (by_st_q == WAIT_HIGH) begin
         if (stb_q) begin
            hi_d     = rx_sh_q;
            by_st_d  = WAIT_LOW;
            wipe_rdy = 1'b1;
         end
      end else if (stb_q) begin
         cmd_d   = {hi_q, rx_sh_q};
         by_st_d = WAIT_HIGH;
         set_rdy = 1'b1;
      end else if (rx_st_q == RX_IDLE && !start) begin
         to_d = to_q + 1'b1;
         if (to_q == TO_LAST) begin
            by_st_d = WAIT_HIGH;
            hi_d    = '0;
            to_d    = '0;
         end
      end
      rdy_d = set_rdy | (rdy_q & ~clr_cmd_rdy & ~wipe_rdy);
   end

   // Transmitter: shift out {stop, data, start}, each bit held BAUD_DIV clocks
   always_comb begin
      tx_st_d  = tx_st_q;
      tx_cnt_d = tx_cnt_q;
      tx_bit_d = tx_bit_q;
      tx_sh_d  = tx_sh_q;
      done_d   = done_q;
      if (tx_st_q == TX_IDLE) begin
         if (trmt) begin
            tx_st_d  = TX_SEND;
            tx_sh_d  = {1'b1, resp, 1'b0};
            tx_cnt_d = '0;
            tx_bit_d = '0;
            done_d   = 1'b0;
         end
      end else if (tx_cnt_q != LAST) tx_cnt_d = tx_cnt_q + 1'b1;
      else begin
         tx_cnt_d = '0;
         tx_bit_d = tx_bit_q + 1'b1;
         tx_sh_d  = {1'b1, tx_sh_q[9:1]};
         if (tx_bit_q == 4'd9) begin
            tx_st_d = TX_IDLE;
            done_d  = 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// tb_uart_cmd_wrapper: directed checks of command reception, response transmission, timeout and reset
module tb_uart_cmd_wrapper;
   logic clk = 1'b0, rst = 1'b1, RX = 1'b1, trmt = 1'b0, clr_cmd_rdy = 1'b0;
   logic [7:0] resp = '0;
   logic TX, cmd_rdy, tx_done;
   logic [15:0] cmd;
   int total = 0, bad = 0;
   bit auto_clr = 1'b0;

   uart_cmd_wrapper #(.BAUD_DIV(16), .TO_BITS(4)) dut (
      .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
      .clr_cmd_rdy(clr_cmd_rdy), .trmt(trmt), .resp(resp), .tx_done(tx_done)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (auto_clr && cmd_rdy) begin
            clr_cmd_rdy = 1'b0;
            auto_clr = 1'b0;
         end
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int k = 0; k < 10; k++) begin
         RX = f[k];
         tick(16);
      end
   endtask

   task automatic tx_frame(input logic [7:0] r, input bit inject);
      logic [9:0] f;
      f = {1'b1, r, 1'b0};
      trmt = 1'b1;
      resp = r;
      tick(1);
      trmt = 1'b0;
      chk1("tx_done_cleared", tx_done, 1'b0);
      tick(8);
      for (int k = 0; k < 10; k++) begin
         chk1("tx_bit", TX, f[k]);
         if (k == 9) tick(7);
         else if (inject && k == 2) begin
            trmt = 1'b1;
            resp = ~r;
            tick(1);
            trmt = 1'b0;
            tick(15);
         end else tick(16);
      end
      chk1("tx_done_early", tx_done, 1'b0);
      tick(1);
      chk1("tx_done_160", tx_done, 1'b1);
      chk1("tx_idle", TX, 1'b1);
   endtask

   initial begin
      tick(2);
      chk1("rst_tx", TX, 1'b1);
      chk16("rst_cmd", cmd, 16'h0000);
      chk1("rst_rdy", cmd_rdy, 1'b0);
      chk1("rst_done", tx_done, 1'b0);
      rst = 1'b0;
      tick(4);

      send_byte(8'h43, 1'b1);
      chk1("hi_only_rdy", cmd_rdy, 1'b0);
      send_byte(8'hF3, 1'b1);
      chk1("cmd1_rdy", cmd_rdy, 1'b1);
      chk16("cmd1", cmd, 16'h43F3);
      tick(20);
      chk1("cmd1_rdy_held", cmd_rdy, 1'b1);
      clr_cmd_rdy = 1'b1;
      tick(1);
      clr_cmd_rdy = 1'b0;
      chk1("cmd1_cleared", cmd_rdy, 1'b0);

      send_byte(8'h20, 1'b1);
      send_byte(8'h00, 1'b1);
      chk16("cmd2", cmd, 16'h2000);
      chk1("cmd2_rdy", cmd_rdy, 1'b1);
      send_byte(8'h60, 1'b1);
      chk1("hi_drops_rdy", cmd_rdy, 1'b0);
      chk16("cmd_hold", cmd, 16'h2000);
      clr_cmd_rdy = 1'b1;
      auto_clr = 1'b1;
      send_byte(8'h01, 1'b1);
      chk16("cmd3", cmd, 16'h6001);
      chk1("set_beats_clr", cmd_rdy, 1'b1);
      chk1("clr_released", clr_cmd_rdy, 1'b0);
      tick(2);
      chk1("cmd3_rdy_held", cmd_rdy, 1'b1);

      tx_frame(8'hA5, 1'b1);
      tick(16);
      chk1("ignored_trmt_done", tx_done, 1'b1);
      chk1("ignored_trmt_tx", TX, 1'b1);

      send_byte(8'h43, 1'b1);
      chk1("to_hi_rdy", cmd_rdy, 1'b0);
      chk16("to_hi_cmd", cmd, 16'h6001);
      tick(80);
      chk16("to_no_change", cmd, 16'h6001);
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      chk16("timeout_cmd", cmd, 16'h1234);
      chk1("timeout_rdy", cmd_rdy, 1'b1);

      send_byte(8'hAB, 1'b0);
      RX = 1'b1;
      tick(16);
      chk1("frame_err_rdy", cmd_rdy, 1'b1);
      chk16("frame_err_cmd", cmd, 16'h1234);
      RX = 1'b0;
      tick(2);
      RX = 1'b1;
      tick(32);
      chk1("glitch_rdy", cmd_rdy, 1'b1);
      send_byte(8'hCD, 1'b1);
      send_byte(8'hEF, 1'b1);
      chk16("after_err_cmd", cmd, 16'hCDEF);
      chk1("after_err_rdy", cmd_rdy, 1'b1);

      fork
         begin
            trmt = 1'b1;
            resp = 8'h00;
            tick(1);
            trmt = 1'b0;
         end
         begin
            tick(36);
            send_byte(8'hFF, 1'b1);
         end
         begin
            tick(105);
            chk1("pre_rst_tx", TX, 1'b0);
            rst = 1'b1;
            tick(1);
            rst = 1'b0;
            chk1("mid_rst_tx", TX, 1'b1);
            chk16("mid_rst_cmd", cmd, 16'h0000);
            chk1("mid_rst_rdy", cmd_rdy, 1'b0);
            chk1("mid_rst_done", tx_done, 1'b0);
            tick(16);
            chk1("post_rst_tx", TX, 1'b1);
         end
      join
      tick(16);
      chk1("partial_no_cmd", cmd_rdy, 1'b0);
      send_byte(8'h0F, 1'b1);
      send_byte(8'hF0, 1'b1);
      chk16("post_rst_cmd", cmd, 16'h0FF0);
      chk1("post_rst_rdy", cmd_rdy, 1'b1);
      chk1("post_rst_done", tx_done, 1'b0);

      fork
         tx_frame(8'h5A, 1'b0);
         begin
            send_byte(8'hBE, 1'b1);
            send_byte(8'hEF, 1'b1);
         end
      join
      chk16("duplex_cmd", cmd, 16'hBEEF);
      chk1("duplex_rdy", cmd_rdy, 1'b1);
      chk1("duplex_done", tx_done, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
